// File: rtl/datapath_sequencer.sv
// Multi-cycle control sequencer for the 64-bit register-file/ALU/RAM datapath.
// Every control output is a flop loaded from the next state and the next latched instruction fields.
module datapath_sequencer #(
  parameter logic [4:0] FS_AND = 5'b00000,
  parameter logic [4:0] FS_ORR = 5'b00100,
  parameter logic [4:0] FS_ADD = 5'b01000,
  parameter logic [4:0] FS_SUB = 5'b01010
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rn,
  input  logic [4:0]  rm,
  input  logic [11:0] imm,
  output logic        ready,
  output logic        done,
  output logic [4:0]  SA,
  output logic [4:0]  SB,
  output logic [4:0]  DA,
  output logic        w_reg,
  output logic [4:0]  FS,
  output logic        C0,
  output logic        B_Sel,
  output logic [63:0] k,
  output logic        EN_ALU,
  output logic        EN_B,
  output logic        EN_ADDR_ALU,
  output logic        ram_cs,
  output logic        ram_write_en,
  output logic        ram_read_en
);

  typedef enum logic [2:0] {IDLE, EXEC, LD_ADDR, LD_WB, ST, DONE} state_t;

  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_ORR  = 3'd3;
  localparam logic [2:0] OP_ADDI = 3'd4;
  localparam logic [2:0] OP_SUBI = 3'd5;
  localparam logic [2:0] OP_LDUR = 3'd6;
  localparam logic [2:0] OP_STUR = 3'd7;
  localparam logic [4:0] XZR     = 5'd31;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d, rn_q, rn_d, rm_q, rm_d;
  logic [11:0] imm_q, imm_d;
  logic        accept;
  logic [63:0] offset_d;

  logic        ready_d, done_d, w_reg_d, c0_d, b_sel_d;
  logic [4:0]  sa_d, sb_d, da_d, fs_d;
  logic [63:0] k_d;
  logic        en_alu_d, en_b_d, en_addr_d, cs_d, we_d, re_d;

  assign accept   = start && ready;
  assign offset_d = {{55{imm_d[8]}}, imm_d[8:0]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rn_q    <= rn_d;
      rm_q    <= rm_d;
      imm_q   <= imm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = accept ? op  : op_q;
    rd_d    = accept ? rd  : rd_q;
    rn_d    = accept ? rn  : rn_q;
    rm_d    = accept ? rm  : rm_q;
    imm_d   = accept ? imm : imm_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (op)
            OP_LDUR: state_d = LD_ADDR;
            OP_STUR: state_d = ST;
            default: state_d = EXEC;
          endcase
        end
      end
      EXEC:    state_d = DONE;
      LD_ADDR: state_d = LD_WB;
      LD_WB:   state_d = DONE;
      ST:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Decoding the upcoming state lets the control word land in flops on the same edge as the state.
  always_comb begin
    ready_d   = 1'b0;
    done_d    = 1'b0;
    sa_d      = '0;
    sb_d      = '0;
    da_d      = '0;
    w_reg_d   = 1'b0;
    fs_d      = '0;
    c0_d      = 1'b0;
    b_sel_d   = 1'b0;
    k_d       = '0;
    en_alu_d  = 1'b0;
    en_b_d    = 1'b0;
    en_addr_d = 1'b0;
    cs_d      = 1'b0;
    we_d      = 1'b0;
    re_d      = 1'b0;
    case (state_d)
      IDLE: ready_d = 1'b1;
      EXEC: begin
        sa_d     = rn_d;
        da_d     = rd_d;
        en_alu_d = 1'b1;
        w_reg_d  = (rd_d != XZR);
        case (op_d)
          OP_SUB, OP_SUBI: begin
            fs_d = FS_SUB;
            c0_d = 1'b1;
          end
          OP_AND:  fs_d = FS_AND;
          OP_ORR:  fs_d = FS_ORR;
          default: fs_d = FS_ADD;
        endcase
        if (op_d == OP_ADDI || op_d == OP_SUBI) begin
          b_sel_d = 1'b1;
          k_d     = {52'd0, imm_d};
        end else begin
          sb_d = rm_d;
        end
      end
      LD_ADDR, LD_WB: begin
        sa_d      = rn_d;
        b_sel_d   = 1'b1;
        k_d       = offset_d;
        fs_d      = FS_ADD;
        en_addr_d = 1'b1;
        cs_d      = 1'b1;
        re_d      = 1'b1;
        if (state_d == LD_WB) begin
          da_d    = rd_d;
          w_reg_d = (rd_d != XZR);
        end
      end
      ST: begin
        sa_d      = rn_d;
        sb_d      = rd_d;
        b_sel_d   = 1'b1;
        k_d       = offset_d;
        fs_d      = FS_ADD;
        en_addr_d = 1'b1;
        en_b_d    = 1'b1;
        cs_d      = 1'b1;
        we_d      = 1'b1;
      end
      DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ready        <= 1'b1;
      done         <= 1'b0;
      SA           <= '0;
      SB           <= '0;
      DA           <= '0;
      w_reg        <= 1'b0;
      FS           <= '0;
      C0           <= 1'b0;
      B_Sel        <= 1'b0;
      k            <= '0;
      EN_ALU       <= 1'b0;
      EN_B         <= 1'b0;
      EN_ADDR_ALU  <= 1'b0;
      ram_cs       <= 1'b0;
      ram_write_en <= 1'b0;
      ram_read_en  <= 1'b0;
    end else begin
      ready        <= ready_d;
      done         <= done_d;
      SA           <= sa_d;
      SB           <= sb_d;
      DA           <= da_d;
      w_reg        <= w_reg_d;
      FS           <= fs_d;
      C0           <= c0_d;
      B_Sel        <= b_sel_d;
      k            <= k_d;
      EN_ALU       <= en_alu_d;
      EN_B         <= en_b_d;
      EN_ADDR_ALU  <= en_addr_d;
      ram_cs       <= cs_d;
      ram_write_en <= we_d;
      ram_read_en  <= re_d;
    end
  end

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Multi-cycle control sequencer for the 64-bit register-file/ALU/RAM datapath.
- Accepts one pre-decoded instruction per start/ready handshake and drives the datapath control bus over 1–2 execute cycles:
  - register-file selects (SA, SB, DA, w_reg)
  - ALU function (FS, C0, B_Sel, k)
  - tri-state enables (EN_ALU, EN_B, EN_ADDR_ALU)
  - RAM strobes (ram_cs, ram_write_en, ram_read_en)
- Sits between the instruction-decode stage and the datapath. It guarantees that at most one source drives data_bus in any cycle.

Parameters:
- FS_AND, 5'b00000, ALU function code for AND
- FS_ORR, 5'b00100, ALU function code for OR
- FS_ADD, 5'b01000, ALU function code for ADD
- FS_SUB, 5'b01010, ALU function code for ADD with B inverted (used with C0=1)

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  instruction valid; accepted when start && ready
- op  in  3  0 ADD, 1 SUB, 2 AND, 3 ORR, 4 ADDI, 5 SUBI, 6 LDUR, 7 STUR
- rd  in  5  destination register (Rt for LDUR/STUR)
- rn  in  5  first source / base register
- rm  in  5  second source (R-type only)
- imm  in  12  ADDI/SUBI: zero-extended; LDUR/STUR: imm[8:0] sign-extended offset
- ready  out  1  sequencer idle, can accept
- done  out  1  one-cycle pulse on instruction completion
- SA, SB, DA  out  5 each  register-file selects
- w_reg  out  1  register-file write enable
- FS  out  5  ALU function
- C0  out  1  ALU carry-in
- B_Sel  out  1  0 = register B, 1 = k
- k  out  64  immediate to ALU B mux
- EN_ALU, EN_B, EN_ADDR_ALU  out  1 each  tri-state enables
- ram_cs, ram_write_en, ram_read_en  out  1 each  RAM strobes

Behaviour:
- States: IDLE, EXEC, LD_ADDR, LD_WB, ST, DONE. All control outputs are registered (Moore, driven from state plus latched fields).
- Reset (async, reset_n=0):
  - state=IDLE, ready=1, done=0.
  - All enables, w_reg, RAM strobes, B_Sel and C0 = 0; SA/SB/DA/FS/k = 0.
  - Reset mid-instruction aborts it immediately; no done pulse is produced.
- IDLE: ready=1, all enables 0. On start && ready:
  - latch op, rd, rn, rm, imm.
  - Next state: EXEC for op 0–5, LD_ADDR for op 6, ST for op 7.
- start while ready=0 is ignored; it is not queued.
- EXEC (1 cycle), with SA=rn and DA=rd:
  - ADD/SUB/AND/ORR: SB=rm, B_Sel=0.
  - ADDI/SUBI: B_Sel=1, k={52'b0,imm}.
  - FS per op; C0=1 only for SUB/SUBI.
  - EN_ALU=1; w_reg=1 unless rd==31 (XZR write suppressed). Next: DONE.
- LD_ADDR (1 cycle):
  - SA=rn, B_Sel=1, k=sext(imm[8:0]), FS=FS_ADD, C0=0, EN_ADDR_ALU=1.
  - ram_cs=1, ram_read_en=1, ram_write_en=0, EN_ALU=0, EN_B=0, w_reg=0. Next: LD_WB.
- LD_WB (1 cycle):
  - Address, FS, k and RAM strobes held as in LD_ADDR; RAM drives data_bus.
  - DA=rd, w_reg=1 unless rd==31. Next: DONE.
- ST (1 cycle):
  - SA=rn, B_Sel=1, k=sext(imm[8:0]), FS=FS_ADD, EN_ADDR_ALU=1.
  - SB=rd, EN_B=1, ram_cs=1, ram_write_en=1, ram_read_en=0, EN_ALU=0, w_reg=0. Next: DONE.
- DONE: all enables 0, done=1 for exactly one cycle, ready=0. Next: IDLE.
- Latency from the accept edge to the done pulse:
  - ALU ops: done high in the 2nd cycle after accept.
  - LDUR: 3rd cycle after accept.
  - STUR: 2nd cycle after accept.
  - Back-to-back: the next accept is possible in the cycle after done (IDLE).
- Bus invariant, checked every cycle: EN_ALU + EN_B + (ram_cs && ram_read_en && !ram_write_en) ≤ 1.
- Write-strobe invariants: ram_write_en=1 implies ram_cs=1 and EN_ADDR_ALU=1; ram_write_en and ram_read_en are never both 1.
- Sign-extension boundaries: imm[8:0]=9'h100 → k=64'hFFFF_FFFF_FFFF_FF00; imm[8:0]=9'h0FF → k=64'h0000_0000_0000_00FF. Upper imm[11:9] is ignored for LDUR/STUR.

Test Plan:
- Reset then ADDI: reset_n low 3 cycles, release, op=4 rd=2 rn=31 imm=12'h005 → EXEC cycle has B_Sel=1, k=5, FS=FS_ADD, EN_ALU=1, w_reg=1, DA=2; done pulses once; r2 reads 5.
- SUB: r1=9, r2=4, then op=1 rd=3 rn=1 rm=2 → EXEC has FS=FS_SUB, C0=1, SB=2; r3=5; done 2 cycles after accept.
- STUR/LDUR: op=7 rd=3 rn=31 imm=9'h010, then op=6 rd=4 rn=31 imm=9'h010 → ST cycle has EN_B=1 and ram_write_en=1; LD_WB has w_reg=1, DA=4; r4=5; LDUR done 3 cycles after accept.
- Negative offset: base r1=9'h20 value, STUR imm=9'h1F8 → RAM address 0x18, k=64'hFFFF_FFFF_FFFF_FFF8.
- XZR and ignored start: ADD with rd=31 → w_reg stays 0 throughout. start held high during LD_ADDR → no second accept; exactly one done.
- Reset mid-LDUR: assert reset_n=0 during LD_WB → all enables drop asynchronously in the same cycle, no done pulse, ready=1 after release; the bus invariant holds over the whole run.
